// File: rtl/hsid_fifo_reader_if.sv
// rtl/hsid_fifo_reader_if.sv - FIFO read port and output stream bundle for hsid_fifo_reader
interface hsid_fifo_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic                  fifo_loop_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_almost_full;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_final;

  modport master (
    output fifo_rd_en,
    output fifo_loop_en,
    input  fifo_data_out,
    input  fifo_empty,
    input  fifo_almost_full,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last,
    output m_final
  );

  modport slave (
    input  fifo_rd_en,
    input  fifo_loop_en,
    output fifo_data_out,
    output fifo_empty,
    output fifo_almost_full,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last,
    input  m_final
  );
endinterface

// File: rtl/hsid_fifo_reader.sv
// rtl/hsid_fifo_reader.sv - replays a FIFO-resident vector num_passes times onto a valid/ready stream
module hsid_fifo_reader #(
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int PASS_WIDTH = 16,
  localparam int ELEM_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  start,
  input  logic [ELEM_WIDTH-1:0] num_elems,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  hsid_fifo_reader_if.master    bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [ELEM_WIDTH-1:0]      elems_q, elems_d;
  logic [PASS_WIDTH-1:0]      passes_q, passes_d;
  logic [ELEM_WIDTH-1:0]      elem_q, elem_d;
  logic [PASS_WIDTH-1:0]      pass_q, pass_d;
  logic                       inflight_q, inflight_d;
  logic                       tag_last_q, tag_last_d;
  logic                       tag_final_q, tag_final_d;
  logic [1:0][DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [1:0]                 buf_last_q, buf_last_d;
  logic [1:0]                 buf_final_q, buf_final_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 count_q, count_d;

  logic       req;
  logic       pop;
  logic       room;
  logic       last_pass;
  logic       elem_wrap;
  logic [2:0] occ;

  assign pop       = bus.m_valid && bus.m_ready;
  assign last_pass = (pass_q == passes_q - PASS_WIDTH'(1));
  assign elem_wrap = (elem_q == elems_q - ELEM_WIDTH'(1));

  // Occupancy after this cycle's pop; keeping it below 2 before a request
  // guarantees the returning word always has a free buffer slot.
  assign occ  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign room = (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    elems_d     = elems_q;
    passes_d    = passes_q;
    elem_d      = elem_q;
    pass_d      = pass_q;
    tag_last_d  = tag_last_q;
    tag_final_d = tag_final_q;
    req         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          elems_d  = num_elems;
          passes_d = num_passes;
          elem_d   = '0;
          pass_d   = '0;
          state_d  = (num_elems == '0 || num_passes == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (bus.fifo_almost_full) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (!bus.fifo_empty && room) begin
          req         = 1'b1;
          tag_last_d  = elem_wrap;
          tag_final_d = elem_wrap && last_pass;
          if (elem_wrap) begin
            elem_d = '0;
            pass_d = pass_q + PASS_WIDTH'(1);
            if (last_pass) state_d = S_DRAIN;
          end else begin
            elem_d = elem_q + ELEM_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pop && bus.m_final) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (clear) begin
      state_d = S_IDLE;
      req     = 1'b0;
    end
  end

  assign inflight_d = req;

  // Read data lands one cycle after its request; the tags travel alongside it.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_final_d = buf_final_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + {1'b0, inflight_q} - {1'b0, pop};
    if (inflight_q) begin
      buf_data_d[wr_ptr_q]  = bus.fifo_data_out;
      buf_last_d[wr_ptr_q]  = tag_last_q;
      buf_final_d[wr_ptr_q] = tag_final_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (clear) begin
      count_d  = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elems_q     <= '0;
      passes_q    <= '0;
      elem_q      <= '0;
      pass_q      <= '0;
      inflight_q  <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_final_q <= 1'b0;
      buf_data_q  <= '0;
      buf_last_q  <= '0;
      buf_final_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      elems_q     <= elems_d;
      passes_q    <= passes_d;
      elem_q      <= elem_d;
      pass_q      <= pass_d;
      inflight_q  <= inflight_d;
      tag_last_q  <= tag_last_d;
      tag_final_q <= tag_final_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_final_q <= buf_final_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign bus.fifo_rd_en   = req && last_pass;
  assign bus.fifo_loop_en = req && !last_pass;
  assign bus.m_valid      = (count_q != 2'd0);
  assign bus.m_data       = buf_data_q[rd_ptr_q];
  assign bus.m_last       = bus.m_valid && buf_last_q[rd_ptr_q];
  assign bus.m_final      = bus.m_valid && buf_final_q[rd_ptr_q];
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);

endmodule
